// File: rtl/gb_oam_dma.sv
// OAM DMA bus stage sitting directly behind the core.
// Routes core accesses to external memory, OAM, HRAM or the DMA register,
// and runs the 160-byte OAM copy. While the copy owns the main bus, every
// core access except HRAM and the DMA register reads 8'hFF.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; the core owns the external bus and the OAM port
// START  | one-cycle setup after a DMA register write
// XFER   | one source read per cycle, idx 0..XFER_LEN-1
module gb_oam_dma #(
    parameter int          XFER_LEN  = 160,
    parameter logic [15:0] HRAM_BASE = 16'hFF80,
    parameter logic [15:0] DMA_REG   = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_write,
    input  logic [7:0]  mem_d_in,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    input  logic [7:0]  oam_rdata,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_idx;
    logic [7:0] w_next_idx;
    logic [7:0] r_dma_src;
    logic       r_wr_valid;
    logic [7:0] r_wr_idx;
    logic [7:0] r_wr_data;
    logic [7:0] r_hram [0:126];

    logic       w_is_dma;
    logic       w_is_hram;
    logic       w_is_oam;
    logic       w_dma_wr;
    logic       w_xfer;
    logic [7:0] w_page;
    logic [6:0] w_hram_off;

    assign w_is_dma   = (cpu_addr == DMA_REG);
    assign w_is_hram  = (cpu_addr >= HRAM_BASE) && (cpu_addr <= 16'hFFFE);
    assign w_is_oam   = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    assign w_dma_wr   = cpu_write && w_is_dma;
    assign w_xfer     = (r_state == S_XFER);
    assign w_hram_off = 7'(cpu_addr - HRAM_BASE);
    // Sources E0..FF mirror the C000-DFFF work RAM, as echo RAM does.
    assign w_page     = (r_dma_src < 8'hE0) ? r_dma_src : (r_dma_src - 8'h20);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    // Next state: a DMA register write restarts from any state.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_START: begin
                w_next_state = S_XFER;
                w_next_idx   = 8'h00;
            end
            S_XFER: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = S_IDLE;
                    w_next_idx   = 8'h00;
                end else begin
                    w_next_idx = r_idx + 8'h01;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = 8'h00;
            end
        endcase
        if (w_dma_wr) begin
            w_next_state = S_START;
            w_next_idx   = 8'h00;
        end
    end

    // Source register and the one-deep read->OAM-write pipeline.
    // A read taken in XFER is always committed the next cycle, even when
    // the same cycle restarts the transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dma_src  <= 8'h00;
            r_wr_valid <= 1'b0;
            r_wr_idx   <= 8'h00;
            r_wr_data  <= 8'h00;
        end else begin
            if (w_dma_wr) begin
                r_dma_src <= cpu_d_out;
            end
            r_wr_valid <= w_xfer;
            if (w_xfer) begin
                r_wr_idx  <= r_idx;
                r_wr_data <= mem_d_in;
            end
        end
    end

    // HRAM storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && cpu_write && w_is_hram) begin
            r_hram[w_hram_off] <= cpu_d_out;
        end
    end

    // Bus routing. Everything is held quiet while reset is asserted.
    always_comb begin
        cpu_d_in  = 8'hFF;
        mem_addr  = 16'h0000;
        mem_d_out = 8'h00;
        mem_write = 1'b0;
        oam_addr  = 8'h00;
        oam_wdata = 8'h00;
        oam_we    = 1'b0;
        busy      = 1'b0;
        if (rst) begin
            busy = (r_state != S_IDLE) || r_wr_valid;
            if (w_xfer) begin
                mem_addr = {w_page, r_idx};
            end
            if (r_wr_valid) begin
                oam_addr  = r_wr_idx;
                oam_wdata = r_wr_data;
                oam_we    = 1'b1;
            end
            if (w_is_dma) begin
                cpu_d_in = r_dma_src;
            end else if (w_is_hram) begin
                cpu_d_in = r_hram[w_hram_off];
            end else if (w_is_oam) begin
                if (!w_xfer && !r_wr_valid) begin
                    oam_addr  = cpu_addr[7:0];
                    oam_wdata = cpu_d_out;
                    oam_we    = cpu_write;
                    cpu_d_in  = oam_rdata;
                end
            end else if (!w_xfer) begin
                mem_addr  = cpu_addr;
                mem_d_out = cpu_d_out;
                mem_write = cpu_write;
                cpu_d_in  = mem_d_in;
            end
        end
    end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: routing vector table plus DMA sequences.
// External memory is a fixed function of address so every page is distinct.
module tb_gb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  cpu_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic [7:0]  mem_d_in;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_rdata;
    logic        busy;

    logic [7:0]  oam [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gb_oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_write (cpu_write),
        .cpu_d_in  (cpu_d_in),
        .mem_addr  (mem_addr),
        .mem_d_out (mem_d_out),
        .mem_write (mem_write),
        .mem_d_in  (mem_d_in),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .oam_rdata (oam_rdata),
        .busy      (busy)
    );

    function automatic logic [7:0] fmem(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
    endfunction

    assign mem_d_in  = fmem(mem_addr);
    assign oam_rdata = oam[oam_addr];

    always @(posedge clk) begin
        if (oam_we) oam[oam_addr] <= oam_wdata;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        wr;
        logic [7:0]  din;
        logic        mw;
        logic        ow;
        logic        ma_chk;
        logic [15:0] ma;
        logic        oa_chk;
        logic [7:0]  oa;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        cpu_addr  = a;
        cpu_d_out = d;
        cpu_write = w;
    endtask

    // Writes the DMA register; returns in cycle 1 (START) with the bus idle.
    task automatic trigger(input logic [7:0] src);
        drive(16'hFF46, src, 1'b1);
        step();
        drive(16'h0000, 8'h00, 1'b0);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            #1;
            if (!busy) done = 1;
            else step();
        end
        chk("idle_timeout", 32'(done), 32'd1);
        step();
    endtask

    initial begin
        rst = 1'b0;
        drive(16'h4000, 8'hAB, 1'b1);
        step();
        step();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_oam_we", 32'(oam_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
        chk("rst_cpu_d_in", 32'(cpu_d_in), 32'hFF);
        rst = 1'b1;
        drive(16'h0000, 8'h00, 1'b0);
        step();

        // Idle routing table: addr, dout, wr, din, mw, ow, ma_chk, ma, oa_chk, oa
        vecs.push_back('{16'hFF46, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{16'hFF80, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{16'hFF80, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{16'hFFFE, 8'hEE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{16'hFFFE, 8'h00, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{16'h1234, 8'h00, 1'b0, fmem(16'h1234), 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h00});
        vecs.push_back('{16'h4000, 8'h99, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 16'h4000, 1'b0, 8'h00});
        vecs.push_back('{16'hFE10, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h10});
        vecs.push_back('{16'hFE10, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h10});
        vecs.push_back('{16'hFE9F, 8'hC3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h9F});
        vecs.push_back('{16'hFE9F, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h9F});
        vecs.push_back('{16'hFEA0, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 16'hFEA0, 1'b0, 8'h00});
        vecs.push_back('{16'hFFFF, 8'h00, 1'b0, fmem(16'hFFFF), 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 8'h00});
        vecs.push_back('{16'hFF7F, 8'h00, 1'b0, fmem(16'hFF7F), 1'b0, 1'b0, 1'b1, 16'hFF7F, 1'b0, 8'h00});

        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].addr, vecs[v].dout, vecs[v].wr);
            #1;
            if (!vecs[v].wr) chk($sformatf("vec%0d_din", v), 32'(cpu_d_in), 32'(vecs[v].din));
            chk($sformatf("vec%0d_mem_write", v), 32'(mem_write), 32'(vecs[v].mw));
            chk($sformatf("vec%0d_oam_we", v), 32'(oam_we), 32'(vecs[v].ow));
            if (vecs[v].ma_chk) chk($sformatf("vec%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].ma));
            if (vecs[v].oa_chk) chk($sformatf("vec%0d_oam_addr", v), 32'(oam_addr), 32'(vecs[v].oa));
            step();
        end
        drive(16'h0000, 8'h00, 1'b0);
        step();

        // Full transfer from C0: cycle 1 START, 2..161 XFER, writes 3..162.
        begin
            int busy_cnt = 0, we_cnt = 0, addr_err = 0, data_err = 0;
            trigger(8'hC0);
            for (int c = 1; c <= 165; c++) begin
                #1;
                if (busy) busy_cnt++;
                if (oam_we) we_cnt++;
                if (c == 1) begin
                    chk("start_busy", 32'(busy), 32'd1);
                    chk("start_no_oam_we", 32'(oam_we), 32'd0);
                end
                if (c >= 2 && c <= 161 && mem_addr !== (16'hC000 + 16'(c - 2))) addr_err++;
                if (c == 163) chk("busy_after", 32'(busy), 32'd0);
                step();
            end
            for (int i = 0; i < 160; i++)
                if (oam[i] !== fmem(16'hC000 + 16'(i))) data_err++;
            chk("xfer_busy_cycles", 32'(busy_cnt), 32'd162);
            chk("xfer_oam_we_count", 32'(we_cnt), 32'd160);
            chk("xfer_src_addr_errs", 32'(addr_err), 32'd0);
            chk("xfer_oam_data_errs", 32'(data_err), 32'd0);
        end

        // Core accesses while the transfer owns the bus.
        trigger(8'hC0);
        for (int c = 1; c < 5; c++) step();
        drive(16'h1234, 8'h00, 1'b0);
        #1;
        chk("xfer_rd_ext_ff", 32'(cpu_d_in), 32'hFF);
        chk("xfer_rd_mem_addr", 32'(mem_addr), 32'hC003);
        step();
        drive(16'hFF90, 8'h77, 1'b1);
        #1;
        chk("xfer_hram_wr_no_mw", 32'(mem_write), 32'd0);
        step();
        drive(16'hFF90, 8'h00, 1'b0);
        #1;
        chk("xfer_hram_rd", 32'(cpu_d_in), 32'h77);
        step();
        drive(16'hFF46, 8'h00, 1'b0);
        #1;
        chk("xfer_dma_rd", 32'(cpu_d_in), 32'hC0);
        step();
        drive(16'hD000, 8'h12, 1'b1);
        #1;
        chk("xfer_ext_wr_dropped", 32'(mem_write), 32'd0);
        step();
        drive(16'hFE10, 8'h00, 1'b0);
        #1;
        chk("xfer_oam_rd_ff", 32'(cpu_d_in), 32'hFF);
        drive(16'h0000, 8'h00, 1'b0);
        wait_idle();

        // Source page mapping, including the echo boundary.
        begin
            logic [7:0] srcs  [4] = '{8'hE1, 8'hFF, 8'hE0, 8'hDF};
            logic [7:0] pages [4] = '{8'hC1, 8'hDF, 8'hC0, 8'hDF};
            for (int k = 0; k < 4; k++) begin
                trigger(srcs[k]);
                step();
                #1;
                chk($sformatf("page_%0h", srcs[k]), 32'(mem_addr), 32'({pages[k], 8'h00}));
                wait_idle();
            end
        end

        // Restart at idx 50 (cycle 52).
        begin
            int data_err = 0;
            trigger(8'hC0);
            for (int c = 1; c < 52; c++) step();
            drive(16'hFF46, 8'hD0, 1'b1);
            #1;
            chk("restart_src_addr", 32'(mem_addr), 32'hC032);
            chk("restart_pend_we", 32'(oam_we), 32'd1);
            chk("restart_pend_idx", 32'(oam_addr), 32'd49);
            chk("restart_pend_data", 32'(oam_wdata), 32'(fmem(16'hC031)));
            step();
            drive(16'h0000, 8'h00, 1'b0);
            #1;
            chk("restart_start_busy", 32'(busy), 32'd1);
            step();
            #1;
            chk("restart_first_src", 32'(mem_addr), 32'hD000);
            wait_idle();
            for (int i = 0; i < 160; i++)
                if (oam[i] !== fmem(16'hD000 + 16'(i))) data_err++;
            chk("restart_oam_data_errs", 32'(data_err), 32'd0);
            drive(16'hFF46, 8'h00, 1'b0);
            #1;
            chk("restart_dma_rd", 32'(cpu_d_in), 32'hD0);
            step();
        end

        // Reset at idx 80 (cycle 82); HRAM survives.
        drive(16'hFF80, 8'hA5, 1'b1);
        step();
        drive(16'h0000, 8'h00, 1'b0);
        trigger(8'hC0);
        for (int c = 1; c < 82; c++) step();
        rst = 1'b0;
        drive(16'hFF46, 8'h00, 1'b0);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_oam_we", 32'(oam_we), 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_oam_we", 32'(oam_we), 32'd0);
        chk("postrst_dma_rd", 32'(cpu_d_in), 32'h00);
        step();
        drive(16'hFF80, 8'h00, 1'b0);
        #1;
        chk("postrst_hram", 32'(cpu_d_in), 32'hA5);
        chk("postrst_still_idle", 32'(busy), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_oam_dma.md
Name: gb_oam_dma

Overview:
Bus-side stage directly downstream of the sm83 core. It takes the core's addr/d_out/write bus and routes it to external memory, the OAM port, internal HRAM (FF80–FFFE) or the DMA register (FF46). It runs the 160-byte OAM DMA transfer and, while the transfer owns the main bus, returns 8'hFF for every CPU access except HRAM and FF46. One clk = one bus cycle; all routing is combinational and all state changes on posedge clk.

Parameters:
XFER_LEN, 160, bytes copied per DMA (OAM size)
HRAM_BASE, 16'hFF80, first HRAM address (HRAM spans HRAM_BASE..16'hFFFE, 127 bytes)
DMA_REG, 16'hFF46, DMA source/trigger register address

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
cpu_addr  in  16  core address bus
cpu_d_out  in  8  core write data
cpu_write  in  1  core write strobe
cpu_d_in  out  8  read data returned to core (combinational)
mem_addr  out  16  external memory address
mem_d_out  out  8  external write data
mem_write  out  1  external write strobe
mem_d_in  in  8  external read data, valid in the same cycle
oam_addr  out  8  OAM index 0..159
oam_wdata  out  8  OAM write data
oam_we  out  1  OAM write strobe
oam_rdata  in  8  OAM read data, same cycle
busy  out  1  high while state!=IDLE or an OAM write is pending

Behaviour:
- Reset is rst: synchronous, active-low; clock is clk. While rst=0: state=IDLE, idx=0, dma_src=8'h00, wr_valid=0; mem_write=0, oam_we=0, mem_addr=16'h0000, cpu_d_in=8'hFF, busy=0. HRAM contents are not cleared.
- States: IDLE -> START on a CPU write to DMA_REG. START -> XFER after 1 cycle. XFER -> IDLE after the read with idx=XFER_LEN-1.
- A DMA_REG write in any state latches cpu_d_out into dma_src and enters START with idx=0. This restarts a transfer in progress.
- XFER read cycle: mem_addr={page,idx}, mem_write=0, mem_d_in latched into wr_data, wr_idx<=idx, wr_valid<=1, idx<=idx+1.
  - page=dma_src when dma_src<8'hE0; otherwise page=dma_src-8'h20 (echo of C000–DFFF).
- OAM write trails its read by one cycle: when wr_valid=1, drive oam_addr=wr_idx, oam_wdata=wr_data, oam_we=1.
  - wr_valid clears the cycle after the last read unless another read occurs.
  - A pending write is always committed, including across a restart.
- Timing: DMA_REG write at edge 0 gives START in cycle 1, XFER in cycles 2..161, OAM writes in cycles 3..162, IDLE from cycle 162. busy is high in cycles 1..162.
- CPU routing, in decode priority order:
  1. DMA_REG: reads return dma_src in every state.
  2. HRAM: internal 127x8 array. Writes occur at posedge; reads are combinational. Serviced in every state.
  3. FE00–FE9F: when state!=XFER and wr_valid=0, CPU uses the OAM port (oam_addr=cpu_addr[7:0], oam_we=cpu_write). Otherwise reads return 8'hFF and writes are dropped.
  4. All other addresses: when state!=XFER, pass through to mem_addr/mem_d_out/mem_write/mem_d_in. During XFER, reads return 8'hFF and writes are dropped (mem_write stays 0 for CPU).
- FEA0–FEFF is not OAM and goes to the external bus.
- The DMA never writes HRAM or the DMA register. idx is 8 bits, compared against XFER_LEN-1, and never exceeds 159.

Test Plan:
1. Preload C000..C09F with i^8'h5A; write FF46=8'hC0. Required: START 1 cycle, then 160 reads C000..C09F; oam_we pulses 160 times, OAM[i]=i^8'h5A; busy high exactly 162 cycles, then 0.
2. During XFER: CPU reads 1234 -> 8'hFF with no mem access; CPU writes FF90=8'h77 and reads it back -> 8'h77; CPU reads FF46 -> 8'hC0; CPU write to D000 -> mem_write stays 0.
3. Write FF46=8'hE1. Required: source reads start at C100; write FF46=8'hFF -> source reads start at DF00.
4. Restart: write FF46=8'hC0, then FF46=8'hD0 at XFER idx 50. Required: OAM[49] still written from C031; next cycle START; transfer then copies D000..D09F; OAM[0..159] end equal to D0xx data.
5. Reset mid-XFER (rst=0 for 1 cycle at idx 80). Required: busy=0, oam_we=0, FF46 reads 8'h00 after reset; HRAM FF80 value written before reset is retained.
6. Idle OAM access: CPU writes FE10=8'h3C. Required: oam_we=1, oam_addr=8'h10; read FE10 returns oam_rdata. CPU write to FEA0 -> goes to mem_write.
